// File: rtl/axi4_stream_read_arbiter.sv
// rtl/axi4_stream_read_arbiter.sv - round-robin sharing of one AXI4-Stream slave among bounded readers (optional macro: AXI4_STREAM_READ_ARB_TLAST_EN)
module axi4_stream_read_arbiter #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_NUM_REQ            = 2,
    parameter int C_LEN_WIDTH          = 16
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    input  logic [C_NUM_REQ-1:0]                req,
    input  logic [C_NUM_REQ*C_LEN_WIDTH-1:0]    req_len,
    input  logic [C_NUM_REQ-1:0]                rd_ready,
    output logic [C_NUM_REQ-1:0]                grant,
    output logic                                data_valid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     data,
    output logic                                data_last,
    output logic                                done,
    output logic                                done_short,
    output logic                                busy
);

    localparam int PTR_W = (C_NUM_REQ > 2) ? 2 : 1;
    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE  = C_LEN_WIDTH'(1);
    localparam logic [C_NUM_REQ-1:0]   GNT_ONE  = C_NUM_REQ'(1);
    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(C_NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr, win_q, arb_idx;
    logic                   arb_found;
    logic [C_NUM_REQ-1:0]   grant_q;
    logic [C_LEN_WIDTH-1:0] len_q, beat_cnt;
    logic                   short_q;
    logic                   beat, count_end, tlast_end, final_beat, short_cond;
    logic                   unused_inputs;

    assign unused_inputs = ^{S_AXIS_TSTRB, S_AXIS_TLAST};

    // Round-robin search: first requester at or after rr_ptr, wrapping once.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= C_NUM_REQ) idx = idx - C_NUM_REQ;
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(idx);
            end
        end
    end

    assign beat = (state == XFER) && S_AXIS_TVALID && S_AXIS_TREADY;

`ifdef AXI4_STREAM_READ_ARB_TLAST_EN
    // A zero length means the grant runs until TLAST, so the count never ends it.
    assign count_end  = (len_q != '0) && (beat_cnt == len_q - LEN_ONE);
    assign tlast_end  = S_AXIS_TLAST;
    assign short_cond = tlast_end &&
                        (({1'b0, beat_cnt} + {1'b0, LEN_ONE}) < {1'b0, len_q});
`else
    // A zero length wraps len_q-1 to all ones, giving 2^C_LEN_WIDTH beats.
    assign count_end  = (beat_cnt == len_q - LEN_ONE);
    assign tlast_end  = 1'b0;
    assign short_cond = 1'b0;
`endif

    assign final_beat = beat && (count_end || tlast_end);

    // State register.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) state <= IDLE;
        else               state <= state_nxt;
    end

    // Next state: DONE arbitrates like IDLE so back-to-back grants are two cycles apart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_found) state_nxt = XFER;
            XFER:    if (final_beat) state_nxt = DONE;
            DONE:    state_nxt = arb_found ? XFER : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: load on arbitration, count beats, release on the final beat.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            rr_ptr   <= '0;
            win_q    <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            short_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arb_found) begin
                        grant_q  <= GNT_ONE << arb_idx;
                        win_q    <= arb_idx;
                        len_q    <= req_len[arb_idx*C_LEN_WIDTH +: C_LEN_WIDTH];
                        beat_cnt <= '0;
                        short_q  <= 1'b0;
                    end else begin
                        grant_q  <= '0;
                    end
                end
                XFER: begin
                    if (beat) beat_cnt <= beat_cnt + LEN_ONE;
                    if (final_beat) begin
                        grant_q <= '0;
                        rr_ptr  <= (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
                        short_q <= short_cond;
                    end
                end
                default: grant_q <= '0;
            endcase
        end
    end

    // Stream-side and status outputs, all combinational from state and live inputs.
    always_comb begin
        S_AXIS_TREADY = (state == XFER) && rd_ready[win_q];
        data_valid    = (state == XFER) && S_AXIS_TVALID;
        data_last     = final_beat;
        done          = (state == DONE);
        done_short    = (state == DONE) && short_q;
        busy          = (state != IDLE);
    end

    assign grant = grant_q;
    assign data  = S_AXIS_TDATA;

endmodule

// File: tb/tb_axi4_stream_read_arbiter.sv
// tb/tb_axi4_stream_read_arbiter.sv - directed-vector bench for axi4_stream_read_arbiter
module tb_axi4_stream_read_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            areset;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tlast;
    logic            tvalid;
    logic [NR-1:0]   req;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]   rd_ready;
    logic [NR-1:0]   grant;
    logic            data_valid;
    logic [DW-1:0]   data;
    logic            data_last;
    logic            done;
    logic            done_short;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;

    axi4_stream_read_arbiter #(
        .C_S_AXIS_TDATA_WIDTH(DW),
        .C_NUM_REQ(NR),
        .C_LEN_WIDTH(LW)
    ) dut (
        .S_AXIS_ACLK(clk),
        .S_AXIS_ARESET(areset),
        .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast),
        .S_AXIS_TVALID(tvalid),
        .req(req),
        .req_len(req_len),
        .rd_ready(rd_ready),
        .grant(grant),
        .data_valid(data_valid),
        .data(data),
        .data_last(data_last),
        .done(done),
        .done_short(done_short),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    // Wait (bounded) until a grant is visible; returns it and the cycle it appeared.
    task automatic wait_grant(output logic [NR-1:0] g, output int at);
        g  = '0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (grant != '0) begin
                g  = grant;
                at = cycle;
                return;
            end
            tick();
        end
        check_vec("wait_grant_timeout", 1, 0);
    endtask

    // Runs one grant to its done pulse. rdy_pat bit i drives rd_ready in grant cycle i;
    // tlast_beat (1-based, 0 = never) raises TLAST on that beat.
    task automatic run_grant(input logic [31:0] rdy_pat, input int tlast_beat,
                             output int beats, output int last_at, output int short_seen,
                             output int final_cyc, output int xfer_cycles);
        beats = 0; last_at = 0; short_seen = 0; final_cyc = -1; xfer_cycles = 0;
        for (int c = 0; c < 300; c++) begin
            rd_ready = {NR{rdy_pat[c % 32]}};
            tlast    = (tlast_beat != 0) && (beats + 1 == tlast_beat);
            #1;
            if (done) begin
                short_seen = int'(done_short);
                return;
            end
            check_vec("tready_gate", tready, |(grant & rd_ready));
            if (tready && tvalid) begin
                beats++;
                if (data_last) last_at = beats;
                final_cyc = cycle;
                xfer_cycles = c + 1;
            end
            tick();
        end
        check_vec("run_grant_timeout", 1, 0);
    endtask

    logic [NR-1:0] g;
    int at, prev_final;
    int beats, last_at, short_seen, final_cyc, xcyc;
    logic [NR-1:0] exp_order [3];

    initial begin
        areset = 1'b1; tdata = 32'hA5A5_0001; tstrb = '1; tlast = 1'b0; tvalid = 1'b0;
        req = '0; req_len = '0; rd_ready = '0;
        do_reset();

        // Reset state
        #1;
        check_vec("rst_grant", grant, 0);
        check_vec("rst_tready", tready, 0);
        check_vec("rst_data_valid", data_valid, 0);
        check_vec("rst_data_last", data_last, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_done_short", done_short, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_data_passthru", data, 32'hA5A5_0001);

        // Single request, len 4
        req = 2'b01; req_len = {16'd0, 16'd4}; tvalid = 1'b1; rd_ready = 2'b11;
        #1;
        check_vec("single_grant_before", grant, 0);
        tick();
        check_vec("single_grant_n1", grant, 2'b01);
        check_vec("single_busy", busy, 1);
        req = 2'b00;
        run_grant(32'hFFFF_FFFF, 0, beats, last_at, short_seen, final_cyc, xcyc);
        check_vec("single_beats", beats, 4);
        check_vec("single_last_at", last_at, 4);
        check_vec("single_done_cycle", cycle, final_cyc + 1);
        check_vec("single_done_short", short_seen, 0);
        check_vec("single_done_tready", tready, 0);
        tick();
        check_vec("single_idle_done", done, 0);
        check_vec("single_idle_busy", busy, 0);

        // Backpressure: rd_ready 1,0,0,1 during len 3
        req = 2'b10; req_len = {16'd3, 16'd0};
        wait_grant(g, at);
        check_vec("bp_grant", g, 2'b10);
        req = 2'b00;
        run_grant(32'hFFFF_FFF9, 0, beats, last_at, short_seen, final_cyc, xcyc);
        check_vec("bp_beats", beats, 3);
        check_vec("bp_last_at", last_at, 3);
        check_vec("bp_xfer_cycles", xcyc, 5);
        tick();

        // TLAST on beat 3 of len 8
        req = 2'b01; req_len = {16'd0, 16'd8};
        wait_grant(g, at);
        req = 2'b00;
        run_grant(32'hFFFF_FFFF, 3, beats, last_at, short_seen, final_cyc, xcyc);
        tlast = 1'b0;
`ifdef AXI4_STREAM_READ_ARB_TLAST_EN
        check_vec("tlast_beats", beats, 3);
        check_vec("tlast_last_at", last_at, 3);
        check_vec("tlast_done_short", short_seen, 1);
`else
        check_vec("tlast_beats", beats, 8);
        check_vec("tlast_last_at", last_at, 8);
        check_vec("tlast_done_short", short_seen, 0);
`endif
        tick();

        // Contention from a fresh reset: 01, 10, 01 with a 2-cycle gap
        do_reset();
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
        req = 2'b11; req_len = {16'd2, 16'd2}; prev_final = 0;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g, at);
            check_vec($sformatf("cont_grant_%0d", k), g, exp_order[k]);
            if (k > 0) check_vec($sformatf("cont_gap_%0d", k), at - prev_final, 2);
            if (k == 2) req = 2'b00;
            run_grant(32'hFFFF_FFFF, 0, beats, last_at, short_seen, final_cyc, xcyc);
            check_vec($sformatf("cont_beats_%0d", k), beats, 2);
            prev_final = final_cyc;
        end
        tick();
        check_vec("cont_idle_grant", grant, 0);

        // Reset after 2 of 5 beats (rr_ptr is 1 here from the last 01 grant)
        req = 2'b01; req_len = {16'd5, 16'd5};
        wait_grant(g, at);
        req = 2'b00;
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        check_vec("mid_rst_grant", grant, 0);
        check_vec("mid_rst_tready", tready, 0);
        check_vec("mid_rst_done", done, 0);
        check_vec("mid_rst_busy", busy, 0);
        tick();
        check_vec("mid_rst_done_later", done, 0);
        req = 2'b11;
        wait_grant(g, at);
        check_vec("post_rst_winner", g, 2'b01);
        req = 2'b00;
        run_grant(32'hFFFF_FFFF, 0, beats, last_at, short_seen, final_cyc, xcyc);
        check_vec("post_rst_beats", beats, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
